// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the configuration loader and the fabric top:
// loader FSM state encoding, default fabric geometry and sizing helpers.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    SETTLE,
    FFEN,
    DONE
  } cfg_state_t;

  localparam int CFG_ROW_W    = 224;
  localparam int CFG_NUM_ROWS = 43;
  localparam int CFG_IN_W     = 32;

  // Number of stream words needed to fill one configuration row.
  function automatic int words_per_row(input int row_w, input int in_w);
    return (row_w + in_w - 1) / in_w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpga_config_loader_row_asm.sv
// Row assembler: drops each accepted stream word into its slot of the row
// register and flags the word that completes the row. Bits of the last word
// that fall above ROW_W are discarded.
module cfg_row_assembler
  import fpga_cfg_pkg::*;
#(
  parameter int ROW_W = CFG_ROW_W,
  parameter int IN_W  = CFG_IN_W
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clr,
  input  logic             xfer,
  input  logic [IN_W-1:0]  s_data,
  output logic [ROW_W-1:0] row_data,
  output logic             row_full
);

  localparam int WPR   = words_per_row(ROW_W, IN_W);
  localparam int PAD_W = WPR * IN_W;
  localparam int CNT_W = cnt_w(WPR);

  logic [CNT_W-1:0] word_cnt;
  logic [ROW_W-1:0] row_q;
  logic [PAD_W-1:0] row_ext;

  assign row_full = xfer && (word_cnt == CNT_W'(WPR - 1));
  assign row_data = row_q;

  // Current row with the incoming word merged into the slot it is addressed to.
  always_comb begin
    row_ext = PAD_W'(row_q);
    for (int k = 0; k < WPR; k++) begin
      if (word_cnt == CNT_W'(k)) row_ext[k*IN_W +: IN_W] = s_data;
    end
  end

  // Capture accepted words; the row holds its value between words and after the write.
  always_ff @(posedge clock) begin
    if (rst) begin
      word_cnt <= '0;
      row_q    <= '0;
    end else if (clr) begin
      word_cnt <= '0;
    end else if (xfer) begin
      row_q    <= row_ext[ROW_W-1:0];
      word_cnt <= row_full ? '0 : word_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Bitstream loader in front of the fabric: collects stream words into rows,
// strobes each row into the fabric once, waits a settle interval, then
// enables the fabric flip-flops and reports ready.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int ROW_W         = CFG_ROW_W,
  parameter int NUM_ROWS      = CFG_NUM_ROWS,
  parameter int IN_W          = CFG_IN_W,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ROW_W-1:0]    configs_in,
  output logic [NUM_ROWS-1:0] configs_en,
  output logic                ff_en,
  output logic                rdy,
  output logic                busy
);

  localparam int ROW_CW = cnt_w(NUM_ROWS);
  localparam int SET_CW = cnt_w(SETTLE_CYCLES);

  cfg_state_t        state;
  logic [ROW_CW-1:0] row_idx;
  logic [SET_CW-1:0] settle_cnt;
  logic              xfer;
  logic              clr;
  logic              row_full;

  assign xfer = s_valid & s_ready;
  assign clr  = start && ((state == IDLE) || (state == DONE));

  cfg_row_assembler #(
    .ROW_W (ROW_W),
    .IN_W  (IN_W)
  ) u_row_asm (
    .clock    (clock),
    .rst      (rst),
    .clr      (clr),
    .xfer     (xfer),
    .s_data   (s_data),
    .row_data (configs_in),
    .row_full (row_full)
  );

  // Load sequencer with registered handshake, strobe and status outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
      busy       <= 1'b0;
      row_idx    <= '0;
      settle_cnt <= '0;
    end else begin
      configs_en <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
            row_idx    <= '0;
            settle_cnt <= '0;
          end
        end
        COLLECT: begin
          if (row_full) begin
            state      <= WRITE;
            s_ready    <= 1'b0;
            configs_en <= NUM_ROWS'(1) << row_idx;
          end
        end
        WRITE: begin
          // The last row leaves row_idx in place so the pointer never wraps.
          if (row_idx == ROW_CW'(NUM_ROWS - 1)) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end else begin
            state   <= COLLECT;
            s_ready <= 1'b1;
            row_idx <= row_idx + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SET_CW'(SETTLE_CYCLES - 1)) begin
            state <= FFEN;
            ff_en <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        FFEN: begin
          state <= DONE;
          rdy   <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Self-checking bench for fpga_config_loader. The reference model tracks the
// words handed to the loader as a queue of expected rows and derives strobe
// timing, settle timing and status flags from cycle arithmetic.
module tb_fpga_config_loader;

  localparam int ROW_W    = 224;
  localparam int NUM_ROWS = 43;
  localparam int IN_W     = 32;
  localparam int WPR      = 7;
  localparam int SETTLE   = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                rst     = 1'b1;
  logic                start   = 1'b0;
  logic                s_valid = 1'b0;
  logic [IN_W-1:0]     s_data  = '0;
  logic                s_ready;
  logic [ROW_W-1:0]    configs_in;
  logic [NUM_ROWS-1:0] configs_en;
  logic                ff_en;
  logic                rdy;
  logic                busy;

  fpga_config_loader #(
    .ROW_W         (ROW_W),
    .NUM_ROWS      (NUM_ROWS),
    .IN_W          (IN_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .configs_in (configs_in),
    .configs_en (configs_en),
    .ff_en      (ff_en),
    .rdy        (rdy),
    .busy       (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int vmode       = 3;   // 0 always valid, 1 toggling, 2 random, 3 idle
  int dmode       = 0;   // 0 words = row*16+k, 1 random words
  int wi          = 0;
  int kcnt        = 0;
  int strobes     = 0;
  int last_strobe = -1;
  int prev_strobe = -1;
  bit pend_rst    = 1'b1;
  bit pend_start  = 1'b0;
  bit exp_busy    = 1'b0;
  bit exp_ff      = 1'b0;
  bit exp_rdy     = 1'b0;
  bit v_at_strobe = 1'b0;

  logic [IN_W-1:0]  cur_word = '0;
  logic [ROW_W-1:0] exp_row  = '0;
  logic [ROW_W-1:0] row_q[$];
  int               due_q[$];

  function automatic logic [IN_W-1:0] gen_word(input int idx);
    if (dmode == 0) return IN_W'((idx / WPR) * 16 + idx % WPR);
    return $urandom();
  endfunction

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit busy_after);
    wi          = 0;
    kcnt        = 0;
    strobes     = 0;
    last_strobe = -1;
    prev_strobe = -1;
    row_q.delete();
    due_q.delete();
    exp_ff      = 1'b0;
    exp_rdy     = 1'b0;
    exp_busy    = busy_after;
    cur_word    = gen_word(0);
  endtask

  // One clock cycle: update the model for the edge just taken, check outputs,
  // then drive the inputs for the next edge.
  task automatic step(input bit do_start = 1'b0, input bit do_rst = 1'b0);
    bit strobe_now;
    @(negedge clock);
    cyc++;
    if (pend_rst) model_clear(1'b0);
    else if (pend_start) model_clear(1'b1);
    if (exp_busy && last_strobe >= 0 && cyc == last_strobe + SETTLE + 1) exp_ff = 1'b1;
    if (exp_busy && last_strobe >= 0 && cyc == last_strobe + SETTLE + 2) begin
      exp_rdy  = 1'b1;
      exp_busy = 1'b0;
      chk("words_total", ROW_W'(wi), ROW_W'(NUM_ROWS * WPR));
    end

    chk("onehot", ROW_W'($onehot0(configs_en)), ROW_W'(1));
    strobe_now = (configs_en != '0);
    if (strobe_now) begin
      chk("strobe_row", ROW_W'(configs_en), ROW_W'({{(NUM_ROWS-1){1'b0}}, 1'b1} << strobes));
      if (row_q.size() == 0 || due_q.size() == 0) begin
        chk("strobe_expected", ROW_W'(row_q.size()), ROW_W'(1));
      end else begin
        chk("row_data", configs_in, row_q.pop_front());
        chk("strobe_time", ROW_W'(cyc), ROW_W'(due_q.pop_front()));
      end
      chk("ready_in_write", ROW_W'(s_ready), ROW_W'(0));
      if (prev_strobe >= 0 && vmode == 0)
        chk("spacing", ROW_W'(cyc - prev_strobe), ROW_W'(WPR + 1));
      if (prev_strobe >= 0 && vmode == 1)
        chk("spacing_bp", ROW_W'(cyc - prev_strobe), ROW_W'(v_at_strobe ? 2*WPR + 1 : 2*WPR));
      prev_strobe = cyc;
      strobes++;
      if (strobes == NUM_ROWS) last_strobe = cyc;
    end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
      chk("strobe_missing", ROW_W'(configs_en), ROW_W'({{(NUM_ROWS-1){1'b0}}, 1'b1} << strobes));
      void'(due_q.pop_front());
      void'(row_q.pop_front());
    end
    chk("ff_en", ROW_W'(ff_en), ROW_W'(exp_ff));
    chk("rdy", ROW_W'(rdy), ROW_W'(exp_rdy));
    chk("busy", ROW_W'(busy), ROW_W'(exp_busy));
    if (!exp_busy) chk("ready_idle", ROW_W'(s_ready), ROW_W'(0));

    rst        = do_rst;
    start      = do_start;
    pend_rst   = do_rst;
    pend_start = do_start && !exp_busy && !do_rst;
    case (vmode)
      0:       s_valid = 1'b1;
      1:       s_valid = ~s_valid;
      2:       s_valid = ($urandom_range(0, 3) != 0);
      default: s_valid = 1'b0;
    endcase
    s_data = cur_word;
    if (strobe_now) v_at_strobe = s_valid;
    if (s_valid && s_ready && !do_rst) begin
      exp_row[kcnt*IN_W +: IN_W] = s_data;
      kcnt++;
      wi++;
      if (kcnt == WPR) begin
        row_q.push_back(exp_row);
        due_q.push_back(cyc + 1);
        kcnt = 0;
      end
      cur_word = gen_word(wi);
    end
  endtask

  task automatic run_load(input string tag);
    step();
    for (int i = 0; i < 4000 && !exp_rdy; i++) step();
    chk({tag, "_rdy"}, ROW_W'(rdy), ROW_W'(1));
    chk({tag, "_rows"}, ROW_W'(strobes), ROW_W'(NUM_ROWS));
    repeat (2) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_in"}, configs_in, '0);
    chk({tag, "_cfg_en"}, ROW_W'(configs_en), '0);
    chk({tag, "_s_ready"}, ROW_W'(s_ready), '0);
    chk({tag, "_ff_en"}, ROW_W'(ff_en), '0);
    chk({tag, "_rdy"}, ROW_W'(rdy), '0);
    chk({tag, "_busy"}, ROW_W'(busy), '0);
  endtask

  initial begin
    // Reset held for two cycles, then valid data offered while idle.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_all_zero("reset");
    vmode = 0;
    repeat (4) step();
    chk_all_zero("idle_valid");

    // Full load with a continuous stream of patterned words.
    dmode = 0;
    step(1'b1);
    run_load("full");

    // Restart from DONE with the source toggling valid every cycle.
    vmode = 1;
    step(1'b1);
    run_load("backpressure");

    // Random data and random gaps; a start issued mid-load is ignored.
    vmode = 2;
    dmode = 1;
    step(1'b1);
    for (int i = 0; i < 3000; i++) begin
      step();
      if (strobes == 5) break;
    end
    chk("reach_row5", ROW_W'(strobes), ROW_W'(5));
    step(1'b1);
    run_load("busy_start");

    // Reset in the middle of row 20, then a fresh load from row 0.
    vmode = 0;
    dmode = 0;
    step(1'b1);
    for (int i = 0; i < 3000; i++) begin
      step();
      if (strobes == 20 && kcnt == 3) break;
    end
    chk("reach_row20", ROW_W'(strobes), ROW_W'(20));
    step(1'b0, 1'b1);
    step();
    chk_all_zero("mid_reset");
    step(1'b1);
    run_load("after_reset");

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
